// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings and load/store unit helpers.
package riscv_pkg;

  // Major opcodes seen by the load/store unit
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_t;

  // Memory access size/sign encodings carried in funct3
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_mem_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT_R,
    LSU_RESP
  } lsu_state_t;

  // Loads accept B/H/W/BU/HU; stores accept B/H/W only.
  function automatic logic is_legal_mem(input logic [6:0] opcode, input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    if (opcode == OP_LOAD)
      legal = (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    else if (opcode == OP_STORE)
      legal = (funct3 < 3'b011);
    return legal;
  endfunction

  // Half with odd address, or word not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
           ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables and replicated store data for the bus,
// plus extraction and sign/zero extension of the returned load word.
// Misaligned low address bits are ignored by construction (half uses addr[1],
// word uses no offset).
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_rsh_b;
  logic [31:0] w_rsh_h;

  assign w_rsh_b = i_rdata >> {i_addr_lo, 3'b000};
  assign w_rsh_h = i_rdata >> {i_addr_lo[1], 4'b0000};

  // Lane selection for the bus side and extension for the load return
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned, which would infer a latch.
    o_be    = 4'hF;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    unique case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_rsh_b[7]}}, w_rsh_b[7:0]};
      F3_BU:   o_rdata = {24'h0, w_rsh_b[7:0]};
      F3_H:    o_rdata = {{16{w_rsh_h[15]}}, w_rsh_h[15:0]};
      F3_HU:   o_rdata = {16'h0, w_rsh_h[15:0]};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a valid/grant memory port.
// One request in flight; FSM IDLE -> REQ -> (WAIT_R) -> RESP -> IDLE.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are
// reported as errors (with a misalign flag) instead of being force-aligned.
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [6:0]      req_opcode,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            done,
  output logic [XLEN-1:0] done_rdata,
  output logic [4:0]      done_rd,
  output logic            done_err,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic            misalign,
`endif
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  lsu_state_t      r_state;
  lsu_state_t      w_state_nxt;
  logic [CW-1:0]   r_tcnt;
  logic            r_is_load;
  logic [2:0]      r_f3;
  logic [1:0]      r_addr_lo;
  logic [4:0]      r_rd;

  logic            w_accept;
  logic            w_legal;
  logic            w_misal;
  logic            w_tmo;
  logic            w_resp_err;
  logic [XLEN-1:0] w_resp_rdata;
  logic [4:0]      w_resp_rd;
  logic [1:0]      w_al_addr_lo;
  logic [2:0]      w_al_f3;
  logic [3:0]      w_al_be;
  logic [XLEN-1:0] w_al_wdata;
  logic [XLEN-1:0] w_al_rdata;

  assign req_ready = (r_state == LSU_IDLE);
  assign stall     = (r_state != LSU_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_legal   = is_legal_mem(req_opcode, req_funct3);
  assign w_tmo     = (r_tcnt == CW'(TIMEOUT_CYC - 1));
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misal   = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign w_misal   = 1'b0;
`endif

  // While idle the aligner sees the incoming request; afterwards the latched one.
  assign w_al_addr_lo = req_ready ? req_addr[1:0] : r_addr_lo;
  assign w_al_f3      = req_ready ? req_funct3    : r_f3;

  lsu_align u_align (
    .i_addr_lo (w_al_addr_lo),
    .i_funct3  (w_al_f3),
    .i_wdata   (req_wdata),
    .i_rdata   (mem_rdata),
    .o_be      (w_al_be),
    .o_wdata   (w_al_wdata),
    .o_rdata   (w_al_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) r_state <= LSU_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and the completion values to register on entry to RESP
  always_comb begin
    w_state_nxt  = r_state;
    w_resp_err   = 1'b0;
    w_resp_rdata = '0;
    w_resp_rd    = '0;
    unique case (r_state)
      LSU_IDLE: begin
        if (w_accept) begin
          if (!w_legal || w_misal) begin
            w_state_nxt = LSU_RESP;
            w_resp_err  = 1'b1;
            w_resp_rd   = (req_opcode == OP_LOAD) ? req_rd : 5'd0;
          end else begin
            w_state_nxt = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        if (mem_gnt) begin
          w_state_nxt = r_is_load ? LSU_WAIT_R : LSU_RESP;
        end else if (w_tmo) begin
          w_state_nxt = LSU_RESP;
          w_resp_err  = 1'b1;
          w_resp_rd   = r_is_load ? r_rd : 5'd0;
        end
      end
      LSU_WAIT_R: begin
        if (mem_rvalid) begin
          w_state_nxt  = LSU_RESP;
          w_resp_rdata = w_al_rdata;
          w_resp_rd    = r_rd;
        end else if (w_tmo) begin
          w_state_nxt = LSU_RESP;
          w_resp_err  = 1'b1;
          w_resp_rd   = r_rd;
        end
      end
      LSU_RESP: w_state_nxt = LSU_IDLE;
      default:  w_state_nxt = LSU_IDLE;
    endcase
  end

  // Timeout counter: cleared on every state change, counts while waiting on the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            r_tcnt <= '0;
    else if (w_state_nxt != r_state)                       r_tcnt <= '0;
    else if (r_state == LSU_REQ || r_state == LSU_WAIT_R)  r_tcnt <= r_tcnt + 1'b1;
  end

  // Request latch, bus outputs and completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_load  <= 1'b0;
      r_f3       <= '0;
      r_addr_lo  <= '0;
      r_rd       <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      done_err   <= 1'b0;
      done_rdata <= '0;
      done_rd    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign   <= 1'b0;
`endif
    end else begin
      mem_req <= (w_state_nxt == LSU_REQ);
      done    <= (w_state_nxt == LSU_RESP);
      if (w_state_nxt == LSU_RESP) begin
        done_err   <= w_resp_err;
        done_rdata <= w_resp_rdata;
        done_rd    <= w_resp_rd;
      end else begin
        done_err   <= 1'b0;
        done_rdata <= '0;
        done_rd    <= '0;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      misalign <= w_accept && w_legal && w_misal;
`endif
      if (w_accept && (w_state_nxt == LSU_REQ)) begin
        r_is_load <= (req_opcode == OP_LOAD);
        r_f3      <= req_funct3;
        r_addr_lo <= req_addr[1:0];
        r_rd      <= req_rd;
        mem_we    <= (req_opcode == OP_STORE);
        mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
        mem_be    <= w_al_be;
        mem_wdata <= w_al_wdata;
      end
    end
  end

endmodule
